// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs instruction fields into 32-bit MIPS-style words and issues them
//   with sequential word addresses to an instruction-memory write port.
//   The output is a single register stage, so the latency is one cycle.
//
// Parameters
//   ADDR_W     word-address width of the write port
//   BASE_ADDR  first word address issued after reset or restart
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   restart    in   synchronous clear of the address stream and held word
//   in_valid   in   request fields valid
//   in_ready   out  request accepted when in_valid && in_ready
//   op_sel     in   0=R-type 1=LW 2=SW 3=BEQ 4=JAL 5=JR 6..7=illegal
//   rs/rt/rd/shamt/funct/imm/target   in   instruction fields
//   out_valid  out  instr/addr valid
//   out_ready  in   sink accepts when out_valid && out_ready
//   instr      out  encoded word
//   addr       out  word address of instr
//   err        out  one-cycle pulse after an accepted illegal op_sel
//   wrapped    out  sticky flag, address counter has wrapped
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The producer holds its payload stable while valid && !ready, and
// ready never depends on the same side's valid.

module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  localparam logic [2:0] OP_R   = 3'd0;
  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_BEQ = 3'd3;
  localparam logic [2:0] OP_JAL = 3'd4;
  localparam logic [2:0] OP_JR  = 3'd5;

  logic              r_out_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_err;
  logic              r_wrapped;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_load;
  logic [31:0]       w_enc;

  // The register can take a new word when it is empty or being drained in
  // this same cycle; reset and restart block acceptance outright.
  assign w_in_ready = !reset && !restart && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_legal    = (op_sel <= OP_JR);
  assign w_load     = w_accept && w_legal;

  // Unused fields of each format are simply not referenced.
  always_comb begin
    w_enc = 32'h0;
    case (op_sel)
      OP_R:    w_enc = {6'b000000, rs, rt, rd, shamt, funct};
      OP_LW:   w_enc = {6'b100011, rs, rt, imm};
      OP_SW:   w_enc = {6'b101011, rs, rt, imm};
      OP_BEQ:  w_enc = {6'b000100, rs, rt, imm};
      OP_JAL:  w_enc = {6'b000011, target};
      OP_JR:   w_enc = {6'b001000, rs, 21'b0};
      default: w_enc = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_instr     <= 32'h0;
      r_addr      <= BASE;
      r_next_addr <= BASE;
      r_err       <= 1'b0;
      r_wrapped   <= 1'b0;
    end else if (restart) begin
      // Any held word is dropped without a handshake.
      r_out_valid <= 1'b0;
      r_next_addr <= BASE;
      r_err       <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_instr     <= w_enc;
        r_addr      <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_W'(1);
        if (r_next_addr == {ADDR_W{1'b1}}) begin
          r_wrapped <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign instr     = r_instr;
  assign addr      = r_addr;
  assign err       = r_err;
  assign wrapped   = r_wrapped;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder. Two instances share all inputs: dut_a uses the
// default 8-bit address, dut_b uses ADDR_W=2 to reach the wrap quickly.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [2:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic        in_ready, out_valid, err, wrapped;
  logic [31:0] instr;
  logic [7:0]  addr;
  logic        in_ready_b, out_valid_b, err_b, wrapped_b;
  logic [31:0] instr_b;
  logic [1:0]  addr_b;

  // {instr, addr}
  logic [39:0] exp_q[$];
  int          exp_next;
  int          n_cmp, n_bad;
  int          waits;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .err(err), .wrapped(wrapped)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready_b), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .instr(instr_b), .addr(addr_b), .err(err_b), .wrapped(wrapped_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge. Presents one request, waits (bounded) for
  // acceptance, records the expected word, and returns after the next negedge.
  task automatic send(input logic [2:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
                      input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
                      input logic [15:0] f_imm, input logic [25:0] f_tgt,
                      input logic [31:0] exp_w, output int n_wait);
    op_sel = op; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh; funct = f_fn;
    imm = f_imm; target = f_tgt; in_valid = 1'b1;
    n_wait = 0;
    #1;
    while (!in_ready && n_wait < 20) begin
      @(negedge clk); #1;
      n_wait++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n_wait);
    end else begin
      @(posedge clk);
      if (op <= 3'd5) begin
        exp_q.push_back({exp_w, exp_next[7:0]});
        exp_next = (exp_next + 1) % 256;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every output handshake against the expected queue.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk); #2;
      if (!reset && !restart && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got 0x%08h addr %0d, expected none", instr, addr);
        end else begin
          e = exp_q.pop_front();
          chk("instr",   instr,            e[39:8]);
          chk("addr",    {24'b0, addr},    {24'b0, e[7:0]});
          chk("instr_b", instr_b,          e[39:8]);
          chk("addr_b",  {30'b0, addr_b},  {30'b0, e[1:0]});
          chk("valid_b", {31'b0, out_valid_b}, 32'd1);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; exp_next = 0;
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_sel = 3'd0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    imm = '0; target = '0;

    // Reset: in_ready low while held, then reset values.
    idle(2);
    in_valid = 1'b1; #1;
    chk("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr",     instr,              32'h0);
    chk("rst_addr",      {24'b0, addr},      32'd0);
    chk("rst_err",       {31'b0, err},       32'd0);
    chk("rst_wrapped",   {31'b0, wrapped},   32'd0);
    @(negedge clk);

    // add $3,$1,$2
    out_ready = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h00221820, waits);
    chk("rtype_latency", {31'b0, out_valid}, 32'd1);

    // Restart, then LW and JAL back-to-back from address 0.
    restart = 1'b1; #1;
    chk("in_ready_restart", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    restart = 1'b0; exp_q.delete(); exp_next = 0;
    send(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 32'h8FA80004, waits);
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 32'h0C100000, waits);
    chk("jal_no_wait", waits, 32'd0);
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);

    // Other formats, with junk in the unused fields.
    send(3'd2, 5'd5, 5'd6, 5'd31, 5'd31, 6'h3F, 16'hFFFC, 26'h3FFFFFF, 32'hACA6FFFC, waits);
    send(3'd3, 5'd1, 5'd0, 5'd7, 5'd9, 6'h15, 16'h0003, 26'h1234567, 32'h10200003, waits);
    send(3'd5, 5'd31, 5'd17, 5'd18, 5'd19, 6'h2A, 16'hBEEF, 26'h2AAAAAA, 32'h23E00000, waits);
    send(3'd0, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'hFFFF, 26'h3FFFFFF, 32'h00095100, waits);
    idle(1);

    // Backpressure: word held stable for 3 cycles, then drain + reload.
    out_ready = 1'b0;
    send(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 32'h8C430010, waits);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid",    {31'b0, out_valid}, 32'd1);
      chk("bp_instr",    instr,              32'h8C430010);
      chk("bp_addr",     {24'b0, addr},      32'd6);
      chk("bp_in_ready", {31'b0, in_ready},  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(3'd3, 5'd4, 5'd4, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 32'h1084FFFF, waits);
    chk("bp_reload_wait", waits, 32'd0);
    idle(1);
    #1;
    chk("drained_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);

    // Illegal op_sel 7 and 6: err pulse, nothing loaded, address unchanged.
    send(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 32'h0, waits);
    chk("err_pulse",      {31'b0, err},       32'd1);
    chk("illegal_novalid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("err_one_cycle",  {31'b0, err},       32'd0);
    send(3'd6, 5'd2, 5'd2, 5'd2, 5'd2, 6'h2, 16'h2, 26'h2, 32'h0, waits);
    chk("err_pulse6",     {31'b0, err},       32'd1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 32'h0FFFFFFF, waits);
    chk("err_after_legal", {31'b0, err},      32'd0);
    idle(1);

    // Restart while a word is held: dropped, next word at base, wrapped clear.
    out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h2A, 16'h0, 26'h0, 32'h0021082A, waits);
    idle(1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; exp_q.delete(); exp_next = 0;
    #1;
    chk("rs_valid",    {31'b0, out_valid}, 32'd0);
    chk("rs_wrapped_b", {31'b0, wrapped_b}, 32'd0);
    chk("rs_err",      {31'b0, err},       32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h00221820, waits);
    idle(1);

    // Reset while a word is held.
    out_ready = 1'b0;
    send(3'd2, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0, 32'hACA6FFFC, waits);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; exp_q.delete(); exp_next = 0;
    #1;
    chk("rr_valid", {31'b0, out_valid}, 32'd0);
    chk("rr_instr", instr,              32'h0);
    chk("rr_addr",  {24'b0, addr},      32'd0);
    @(negedge clk);

    // Wrap: dut_b wraps on its 4th word, dut_a on its 256th.
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h00221820, waits);
      if (i == 2) chk("wrap_b_before", {31'b0, wrapped_b}, 32'd0);
      if (i == 3) chk("wrap_b_after",  {31'b0, wrapped_b}, 32'd1);
      if (i == 254) chk("wrap_a_before", {31'b0, wrapped}, 32'd0);
      if (i == 255) chk("wrap_a_after",  {31'b0, wrapped}, 32'd1);
    end
    idle(3);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word-address width of the instruction-memory write port.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, meaning the first word address issued after reset or restart.
REQ-003 Port list SHALL be: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset (one clock; synchronous, active-high reset).
REQ-004 Port: restart  input  1  synchronous clear of the address stream and held word.
REQ-005 Port: in_valid  input  1  request fields valid; in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 Port: op_sel  input  3  0=R-type, 1=LW, 2=SW, 3=BEQ, 4=JAL, 5=JR, 6..7=illegal.
REQ-007 Ports: rs, rt, rd, shamt  input  5 each; funct  input  6; imm  input  16; target  input  26  instruction fields.
REQ-008 Port: out_valid  output  1  word valid; out_ready  input  1  sink accepts when out_valid && out_ready.
REQ-009 Port: instr  output  32  encoded word; addr  output  ADDR_W  word address of instr.
REQ-010 Port: err  output  1  one-cycle pulse on an accepted illegal op_sel; wrapped  output  1  sticky, address counter has wrapped.

Function
REQ-011 Encoding SHALL match the team's control-unit decode table: R-type {6'b000000,rs,rt,rd,shamt,funct}; LW {6'b100011,rs,rt,imm}; SW {6'b101011,rs,rt,imm}; BEQ {6'b000100,rs,rt,imm}; JAL {6'b000011,target}; JR {6'b001000,rs,21'b0}.
REQ-012 Fields not used by the selected op SHALL be ignored.
REQ-013 Output stage SHALL be a single register: in_ready = !restart && (!out_valid || out_ready).
REQ-014 Latency SHALL be exactly one cycle: a legal word accepted on edge N shows out_valid=1 after edge N.
REQ-015 While out_valid=1 && out_ready=0, instr and addr SHALL be held stable.
REQ-016 Output handshake and new legal acceptance in the same cycle SHALL reload the register; out_valid stays 1 with no bubble.
REQ-017 Output handshake with no acceptance SHALL clear out_valid on the next edge.
REQ-018 Internal next_addr SHALL be copied to addr on each legal acceptance, then incremented modulo 2^ADDR_W.
REQ-019 When next_addr increments from 2^ADDR_W-1 to 0, wrapped SHALL set and remain set until reset or restart.
REQ-020 Accepted illegal op_sel SHALL complete the input handshake, load nothing, leave next_addr unchanged, and pulse err=1 for exactly one cycle.
REQ-021 restart=1 SHALL, on that edge, set next_addr=BASE_ADDR, clear out_valid, clear wrapped, clear err, and accept no input (in_ready=0 that cycle).
REQ-022 A held unaccepted word SHALL be discarded by restart or reset with no handshake.

Reset
REQ-023 On reset=1 at a rising edge: out_valid=0, instr=0, addr=BASE_ADDR, next_addr=BASE_ADDR, err=0, wrapped=0.
REQ-024 During reset, in_ready SHALL be 0; reset SHALL take priority over restart and all handshakes, including mid-transfer.

Verification
REQ-025 R-type, rs=1 rt=2 rd=3 shamt=0 funct=0x20, out_ready=1 -> next cycle instr=0x00221820, addr=0, out_valid=1.
REQ-026 LW rs=29 rt=8 imm=0x0004, then JAL target=0x0100000 back-to-back -> instr=0x8FA80004 at addr 0, then 0x0C100000 at addr 1, no bubble.
REQ-027 Backpressure: word loaded, out_ready=0 for 3 cycles -> instr/addr stable, in_ready=0; out_ready=1 -> one handshake, addr advances by 1.
REQ-028 op_sel=7 with in_valid=1 -> err=1 for one cycle, out_valid stays 0, next legal word takes the unchanged address.
REQ-029 ADDR_W=2, five legal words -> addr 0,1,2,3,0; wrapped=1 from the cycle after the 4th acceptance.
REQ-030 Reset or restart asserted while out_valid=1 && out_ready=0 -> out_valid=0 next cycle, next accepted word at BASE_ADDR, wrapped=0.
